// File: rtl/bin2onehot_seq.sv
// Registered binary-to-code decoder with valid/ready handshake: one-hot,
// thermometer, inverted one-hot, or a multi-beat one-hot scan burst.
module bin2onehot_seq #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   bin,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  code,
  output logic              last,
  output logic              err
);

  generate
    if (OUT_W < 2 || OUT_W > (1 << IN_W)) begin : g_bad_param
      $error("bin2onehot_seq: OUT_W must satisfy 2 <= OUT_W <= 2**IN_W");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERM  = 2'b01;
  localparam logic [1:0] MODE_INV    = 2'b10;

  // One extra bit so OUT_W == 2**IN_W is representable for the range check.
  localparam logic [IN_W:0] OUT_W_EXT = (IN_W+1)'(OUT_W);

  logic [1:0]       r_state;
  logic [OUT_W-1:0] r_code;
  logic             r_last;
  logic             r_err;
  logic [IN_W-1:0]  r_beat;
  logic [IN_W-1:0]  r_end;

  logic             w_accept;
  logic             w_out_xfer;
  logic             w_in_range;
  logic [IN_W-1:0]  w_beat_nxt;
  logic [OUT_W-1:0] w_onehot;
  logic [OUT_W-1:0] w_therm;
  logic [OUT_W-1:0] w_beat_oh;

  logic [1:0]       w_ld_state;
  logic [OUT_W-1:0] w_ld_code;
  logic             w_ld_last;
  logic             w_ld_err;

  assign out_valid  = (r_state != ST_IDLE);
  assign in_ready   = !reset && (r_state != ST_SCAN) && (!out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;
  assign code       = r_code;
  assign last       = r_last;
  assign err        = r_err;

  // The beat counter never passes r_end (< OUT_W), so the increment cannot wrap.
  assign w_beat_nxt = r_beat + IN_W'(1);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_in_range = ({1'b0, bin} < OUT_W_EXT);
    w_onehot   = '0;
    w_therm    = '0;
    w_beat_oh  = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_onehot[i]  = ({1'b0, bin} == (IN_W+1)'(i));
      w_therm[i]   = ((IN_W+1)'(i) <= {1'b0, bin});
      w_beat_oh[i] = ({1'b0, w_beat_nxt} == (IN_W+1)'(i));
    end
  end

  // Register image of a freshly accepted transaction.
  always_comb begin
    w_ld_state = ST_HOLD;
    w_ld_code  = '0;
    w_ld_last  = 1'b1;
    w_ld_err   = 1'b0;
    if (!w_in_range) begin
      w_ld_err = 1'b1;
    end else begin
      case (mode)
        MODE_ONEHOT: w_ld_code = w_onehot;
        MODE_THERM:  w_ld_code = w_therm;
        MODE_INV:    w_ld_code = ~w_onehot;
        default: begin
          w_ld_state = ST_SCAN;
          w_ld_code  = OUT_W'(1);
          w_ld_last  = (bin == '0);
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the scan bookkeeping (r_beat/r_end) is reset too, so outputs are never X after reset.
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
      r_beat  <= '0;
      r_end   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HOLD: begin
          if (w_accept) begin
            r_state <= w_ld_state;
            r_code  <= w_ld_code;
            r_last  <= w_ld_last;
            r_err   <= w_ld_err;
            r_beat  <= '0;
            r_end   <= bin;
          end else if (w_out_xfer) begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (w_out_xfer) begin
            if (r_last) begin
              r_state <= ST_IDLE;
            end else begin
              r_beat <= w_beat_nxt;
              r_code <= w_beat_oh;
              r_last <= (w_beat_nxt == r_end);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2onehot_seq.sv
// Directed scoreboard bench: an 8-wide and a 6-wide instance share clk/reset.
module tb_bin2onehot_seq;

  typedef struct packed {
    logic [7:0] code;
    logic       last;
    logic       err;
    logic       in_rdy;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       started = 1'b0;

  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_err;
  logic [2:0] a_bin;
  logic [1:0] a_mode;
  logic [7:0] a_code;

  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_err;
  logic [2:0] b_bin;
  logic [1:0] b_mode;
  logic [5:0] b_code;

  beat_t q_a[$];
  beat_t q_b[$];
  beat_t ea, eb;

  int checks = 0;
  int errors = 0;
  int w;

  always #5 clk = ~clk;

  bin2onehot_seq #(.IN_W(3), .OUT_W(8)) u_dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .bin(a_bin), .mode(a_mode), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .code(a_code), .last(a_last), .err(a_err)
  );

  bin2onehot_seq #(.IN_W(3), .OUT_W(6)) u_dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .bin(b_bin), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .code(b_code), .last(b_last), .err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit which, input beat_t e);
    if (which) q_b.push_back(e);
    else       q_a.push_back(e);
  endtask

  // Reference model: expected beats of one accepted transaction.
  task automatic push_exp(input bit which, input int b, input int m, input int outw);
    beat_t e;
    logic [7:0] mask;
    mask = 8'((1 << outw) - 1);
    e.last = 1'b1; e.err = 1'b0; e.in_rdy = 1'b1;
    if (b >= outw) begin
      e.code = 8'h00; e.err = 1'b1;
      push(which, e);
    end else if (m == 3) begin
      for (int k = 0; k <= b; k++) begin
        e.code = 8'(1 << k); e.last = (k == b); e.in_rdy = 1'b0;
        push(which, e);
      end
    end else begin
      case (m)
        0:       e.code = 8'(1 << b);
        1:       e.code = 8'((1 << (b + 1)) - 1);
        default: e.code = ~(8'(1 << b)) & mask;
      endcase
      push(which, e);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 right after the accepting edge.
  task automatic send(input bit which, input logic [2:0] b, input logic [1:0] m, output int waited);
    if (which) begin b_in_valid = 1'b1; b_bin = b; b_mode = m; end
    else       begin a_in_valid = 1'b1; a_bin = b; a_mode = m; end
    waited = 0;
    @(negedge clk);
    while (!(which ? b_in_ready : a_in_ready) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (which ? b_in_ready : a_in_ready) begin
      push_exp(which, int'(b), int'(m), which ? 6 : 8);
    end else begin
      checks++;
      errors++;
      $error("FAIL send_timeout: in_ready stuck low observed=0 expected=1");
    end
    @(posedge clk);
    #2;
    if (which) b_in_valid = 1'b0;
    else       a_in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((q_a.size() + q_b.size()) != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check(tag, q_a.size() + q_b.size(), 0);
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      check("a_no_x", 32'($isunknown({a_out_valid, a_in_ready, a_code, a_last, a_err})), 0);
      if (a_out_valid) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_out", a_out_valid, 0);
        end else begin
          ea = q_a[0];
          check("a_code", a_code, ea.code);
          check("a_last", a_last, ea.last);
          check("a_err", a_err, ea.err);
          if (a_out_ready) begin
            check("a_in_ready", a_in_ready, ea.in_rdy);
            void'(q_a.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started && !reset) begin
      check("b_no_x", 32'($isunknown({b_out_valid, b_in_ready, b_code, b_last, b_err})), 0);
      if (b_out_valid) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_out", b_out_valid, 0);
        end else begin
          eb = q_b[0];
          check("b_code", {2'b00, b_code}, eb.code);
          check("b_last", b_last, eb.last);
          check("b_err", b_err, eb.err);
          if (b_out_ready) begin
            check("b_in_ready", b_in_ready, eb.in_rdy);
            void'(q_b.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    a_in_valid = 1'b0; a_bin = '0; a_mode = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_bin = '0; b_mode = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", a_out_valid, 0);
    check("rst_code", a_code, 0);
    check("rst_last", a_last, 0);
    check("rst_err", a_err, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    reset = 1'b0;
    started = 1'b1;
    #1;
    check("post_rst_in_ready", a_in_ready, 1);
    #1;

    // One-hot sweep, back-to-back at full rate.
    send(0, 3'd0, 2'b00, w);
    check("latency_valid", a_out_valid, 1);
    check("latency_code", a_code, 8'h01);
    for (int i = 1; i < 8; i++) begin
      send(0, 3'(i), 2'b00, w);
      check("sweep_no_stall", w, 0);
    end
    drain("drain_sweep");

    send(0, 3'd5, 2'b01, w);
    send(0, 3'd2, 2'b10, w);
    drain("drain_therm_inv");

    send(0, 3'd3, 2'b11, w);
    check("scan_in_ready_low", a_in_ready, 0);
    drain("drain_scan3");
    check("scan_done_in_ready", a_in_ready, 1);

    send(0, 3'd0, 2'b11, w);
    drain("drain_scan0");

    // Backpressure in the middle of a scan burst.
    send(0, 3'd2, 2'b11, w);
    @(posedge clk);
    #2;
    check("bp_beat1", a_code, 8'h02);
    a_out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("bp_hold_code", a_code, 8'h02);
      check("bp_hold_valid", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    drain("drain_bp");

    // Out-of-range indices on the 6-wide instance.
    send(1, 3'd6, 2'b00, w);
    send(1, 3'd7, 2'b00, w);
    send(1, 3'd5, 2'b00, w);
    send(1, 3'd7, 2'b10, w);
    send(1, 3'd6, 2'b11, w);
    send(1, 3'd5, 2'b10, w);
    drain("drain_oor");

    // Reset during beat 2 of a full scan.
    send(0, 3'd7, 2'b11, w);
    repeat (2) begin
      @(posedge clk);
      #2;
    end
    check("rst_scan_beat2", a_code, 8'h04);
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("rst_scan_valid", a_out_valid, 0);
    check("rst_scan_code", a_code, 0);
    check("rst_scan_last", a_last, 0);
    q_a.delete();
    reset = 1'b0;
    send(0, 3'd1, 2'b00, w);
    check("after_rst_code", a_code, 8'h02);
    drain("drain_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
